// File: rtl/stack_pkg.sv
// Shared definitions for the stack processor sequencer and control unit.
package stack_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned LAT_W   = 4;

  // Sequencer state encoding; PAUSE exists only in single-step builds.
  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_WAIT_IN = 3'd4,
    S_HALT    = 3'd5,
    S_PAUSE   = 3'd6
  } seq_state_t;

  localparam logic [15:0] OP_HALT  = 16'h0003;
  localparam logic [15:0] OP_GETIN = 16'h0004;

  // "No operation" codes for the control unit stack operation fields.
  localparam logic [2:0] STACKOP_NONE  = 3'd0;
  localparam logic [1:0] RSTACKOP_NONE = 2'd0;

endpackage

// File: rtl/seq_fetch_timer.sv
// Loadable down-counter that times the instruction fetch window.
module seq_fetch_timer
  import stack_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done_c
);

  logic [LAT_W-1:0] count_q;

  // Load latency-1 on FETCH entry, then count down to zero while fetching.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= LAT_W'(MEM_LATENCY - 1);
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - LAT_W'(1);
    end
  end

  assign done_c = (count_q == '0);

endmodule

// File: rtl/stack_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the stack processor.
// Turns decoded control outputs into single-cycle write strobes, owns the
// getin input handshake, halt and the retired-instruction counter.
// Optional: define SEQ_SINGLE_STEP_EN to add the step input and PAUSE state.
module stack_sequencer
  import stack_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic [15:0]      inst,
  input  logic [2:0]       ctl_stackOP,
  input  logic [1:0]       ctl_rStackOP,
  input  logic             ctl_MemWrite,
  input  logic             ctl_PCWrite,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             mem_rd,
  output logic             ir_we,
  output logic             stack_en,
  output logic             rstack_en,
  output logic             mem_we,
  output logic             pc_we,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  // Where an instruction goes once it has completed.
`ifdef SEQ_SINGLE_STEP_EN
  localparam seq_state_t S_AFTER = S_PAUSE;
`else
  localparam seq_state_t S_AFTER = S_FETCH;
`endif

  seq_state_t       state_q;
  seq_state_t       state_d;
  logic             fetch_done_c;
  logic             timer_load_c;
  logic             is_halt_c;
  logic             is_getin_c;
  logic             retire_c;
  logic [CNT_W-1:0] retired_q;

  assign is_halt_c  = (inst == OP_HALT);
  assign is_getin_c = (inst == OP_GETIN);

  // Reload the fetch timer on every entry into FETCH.
  assign timer_load_c = (state_d == S_FETCH) && (state_q != S_FETCH);

  seq_fetch_timer #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_fetch_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load_c),
    .en    (state_q == S_FETCH),
    .done_c(fetch_done_c)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_FETCH;
      S_FETCH:   if (fetch_done_c) state_d = S_DECODE;
      S_DECODE: begin
        if (is_halt_c) begin
          state_d = S_HALT;
        end else if (is_getin_c) begin
          state_d = S_WAIT_IN;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:    state_d = S_AFTER;
      S_WAIT_IN: if (in_valid) state_d = S_AFTER;
      S_HALT:    state_d = S_HALT;
`ifdef SEQ_SINGLE_STEP_EN
      S_PAUSE:   if (step) state_d = S_FETCH;
`endif
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode: strobes exist only in FETCH, EXEC and the WAIT_IN handshake.
  always_comb begin
    mem_rd    = 1'b0;
    ir_we     = 1'b0;
    stack_en  = 1'b0;
    rstack_en = 1'b0;
    mem_we    = 1'b0;
    pc_we     = 1'b0;
    in_ready  = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd = 1'b1;
        ir_we  = fetch_done_c;
      end
      S_EXEC: begin
        stack_en  = (ctl_stackOP != STACKOP_NONE);
        rstack_en = (ctl_rStackOP != RSTACKOP_NONE);
        mem_we    = ctl_MemWrite;
        pc_we     = ctl_PCWrite;
      end
      S_WAIT_IN: begin
        in_ready = 1'b1;
        stack_en = in_valid;
        pc_we    = in_valid;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign retire_c = (state_q == S_EXEC) || ((state_q == S_WAIT_IN) && in_valid);

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
    end else if (retire_c) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench: three sequencers with fetch latencies 1, 3 and 4.
`timescale 1ns/1ps
module tb_stack_sequencer;

  localparam int NDUT  = 3;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [NDUT-1:0]  start_v;
  logic [15:0]      inst;
  logic [2:0]       ctl_stackOP;
  logic [1:0]       ctl_rStackOP;
  logic             ctl_MemWrite;
  logic             ctl_PCWrite;
  logic             in_valid;
`ifdef SEQ_SINGLE_STEP_EN
  logic             step;
`endif
  logic [NDUT-1:0]  in_ready_v, mem_rd_v, ir_we_v, stack_en_v, rstack_en_v;
  logic [NDUT-1:0]  mem_we_v, pc_we_v, halted_v;
  logic [2:0]       state_v   [NDUT];
  logic [CNT_W-1:0] retired_v [NDUT];

  int n_checks = 0;
  int n_err    = 0;
  int exp_ret [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    stack_sequencer #(.MEM_LATENCY(LAT), .CNT_W(CNT_W)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start_v[g]),
`ifdef SEQ_SINGLE_STEP_EN
      .step        (step),
`endif
      .inst        (inst),
      .ctl_stackOP (ctl_stackOP),
      .ctl_rStackOP(ctl_rStackOP),
      .ctl_MemWrite(ctl_MemWrite),
      .ctl_PCWrite (ctl_PCWrite),
      .in_valid    (in_valid),
      .in_ready    (in_ready_v[g]),
      .mem_rd      (mem_rd_v[g]),
      .ir_we       (ir_we_v[g]),
      .stack_en    (stack_en_v[g]),
      .rstack_en   (rstack_en_v[g]),
      .mem_we      (mem_we_v[g]),
      .pc_we       (pc_we_v[g]),
      .halted      (halted_v[g]),
      .state       (state_v[g]),
      .retired     (retired_v[g])
    );
  end

  typedef struct packed {
    logic [2:0] state;
    logic mem_rd, ir_we, stack_en, rstack_en, mem_we, pc_we, in_ready, halted;
  } obs_t;

  typedef struct {
    logic [15:0] iw;
    logic [2:0]  sop;
    logic [1:0]  rsop;
    logic        mw, pcw;
    logic [3:0]  exp;   // {stack_en, rstack_en, mem_we, pc_we} in EXEC
  } vec_t;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic obs_t e_st(input logic [2:0] st);
    obs_t e = '0;
    e.state = st;
    return e;
  endfunction

  function automatic obs_t e_fetch(input logic last);
    obs_t e = e_st(3'd1);
    e.mem_rd = 1'b1;
    e.ir_we  = last;
    return e;
  endfunction

  function automatic obs_t e_exec(input logic [3:0] s);
    obs_t e = e_st(3'd3);
    {e.stack_en, e.rstack_en, e.mem_we, e.pc_we} = s;
    return e;
  endfunction

  function automatic obs_t e_wait(input logic hs);
    obs_t e = e_st(3'd4);
    e.in_ready = 1'b1;
    e.stack_en = hs;
    e.pc_we    = hs;
    return e;
  endfunction

  function automatic obs_t e_halt();
    obs_t e = e_st(3'd5);
    e.halted = 1'b1;
    return e;
  endfunction

  function automatic obs_t act(input int g);
    obs_t a;
    a.state     = state_v[g];
    a.mem_rd    = mem_rd_v[g];
    a.ir_we     = ir_we_v[g];
    a.stack_en  = stack_en_v[g];
    a.rstack_en = rstack_en_v[g];
    a.mem_we    = mem_we_v[g];
    a.pc_we     = pc_we_v[g];
    a.in_ready  = in_ready_v[g];
    a.halted    = halted_v[g];
    return a;
  endfunction

  task automatic chk(input string name, input int g, input obs_t exp);
    obs_t a;
    logic [CNT_W-1:0] er;
    a  = act(g);
    er = CNT_W'(exp_ret[g] % (1 << CNT_W));
    n_checks++;
    if (a !== exp || retired_v[g] !== er) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t: got state=%0d mrd/irwe/st/rst/mwe/pcwe/rdy/hlt=%b retired=%0d, want state=%0d %b retired=%0d",
               name, g, $time, a.state, a[7:0], retired_v[g], exp.state, exp[7:0], er);
    end
  endtask

  // Check at mid-cycle with current inputs, then advance one clock.
  task automatic cyc(input string name, input int g, input obs_t exp);
    #1;
    chk(name, g, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    start_v  = '0;
    in_valid = 1'b0;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      exp_ret[g] = 0;
      chk("reset", g, e_st(3'd0));
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic launch(input int g);
    start_v = '0;
    cyc("idle", g, e_st(3'd0));
    start_v[g] = 1'b1;
    cyc("start", g, e_st(3'd0));
  endtask

  // One instruction from first FETCH cycle to completion (or HALT entry).
  task automatic do_instr(input string name, input int g, input logic [15:0] iw,
                          input logic [2:0] sop, input logic [1:0] rsop,
                          input logic mw, input logic pcw, input int nwait,
                          input logic [3:0] exp_strb);
    inst = iw; ctl_stackOP = sop; ctl_rStackOP = rsop;
    ctl_MemWrite = mw; ctl_PCWrite = pcw; in_valid = 1'b0;
    for (int c = 0; c < lat_of(g); c++) begin
      start_v[g] = rbit();
      cyc({name, "/fetch"}, g, e_fetch(c == lat_of(g) - 1));
    end
    start_v[g] = rbit();
    cyc({name, "/decode"}, g, e_st(3'd2));
    if (iw == 16'h0003) return;
    if (iw == 16'h0004) begin
      for (int w = 0; w < nwait; w++) begin
        start_v[g] = rbit();
        cyc({name, "/wait"}, g, e_wait(1'b0));
      end
      in_valid = 1'b1;
      cyc({name, "/handshake"}, g, e_wait(1'b1));
      in_valid = 1'b0;
    end else begin
      start_v[g] = rbit();
      cyc({name, "/exec"}, g, e_exec(exp_strb));
    end
    exp_ret[g]++;
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b0;
    cyc({name, "/pause"}, g, e_st(3'd6));
    step = 1'b1;
    cyc({name, "/step"}, g, e_st(3'd6));
    step = 1'b0;
`endif
  endtask

  task automatic rand_instr(input string name, input int g, input int allow_halt,
                            output logic was_halt);
    logic [15:0] iw;
    logic [2:0]  sop;
    logic [1:0]  rsop;
    logic        mw, pcw;
    int          r;
    r    = int'($urandom_range(99, 0));
    iw   = 16'($urandom);
    if (r < 10 && allow_halt != 0) iw = 16'h0003;
    else if (r < 25) iw = 16'h0004;
    else if (iw == 16'h0003) iw = 16'h0013;
    sop  = 3'($urandom); rsop = 2'($urandom);
    mw   = rbit();       pcw  = rbit();
    do_instr(name, g, iw, sop, rsop, mw, pcw, int'($urandom_range(4, 0)),
             {sop != 3'd0, rsop != 2'd0, mw, pcw});
    was_halt = (iw == 16'h0003);
  endtask

  vec_t tbl [7];
  logic hlt;

  initial begin
    tbl[0] = '{16'h0000, 3'd2, 2'd0, 1'b0, 1'b1, 4'b1001};  // add
    tbl[1] = '{16'h5000, 3'd3, 2'd0, 1'b1, 1'b1, 4'b1011};  // pop to memory
    tbl[2] = '{16'h4000, 3'd0, 2'd1, 1'b0, 1'b1, 4'b0101};  // jal
    tbl[3] = '{16'h1234, 3'd0, 2'd0, 1'b0, 1'b0, 4'b0000};
    tbl[4] = '{16'h0104, 3'd4, 2'd2, 1'b0, 1'b0, 4'b1100};  // near-miss getin
    tbl[5] = '{16'hFFFF, 3'd7, 2'd3, 1'b1, 1'b1, 4'b1111};
    tbl[6] = '{16'h0002, 3'd1, 2'd0, 1'b1, 1'b0, 4'b1010};

    reset = 1'b0; start_v = '0; inst = '0; ctl_stackOP = '0; ctl_rStackOP = '0;
    ctl_MemWrite = 1'b0; ctl_PCWrite = 1'b0; in_valid = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b0;
`endif
    @(posedge clk);
    #1;

    // Table vectors on every fetch latency.
    for (int g = 0; g < NDUT; g++) begin
      do_reset();
      launch(g);
      for (int i = 0; i < 7; i++)
        do_instr($sformatf("tbl%0d", i), g, tbl[i].iw, tbl[i].sop, tbl[i].rsop,
                 tbl[i].mw, tbl[i].pcw, 0, tbl[i].exp);
    end

    // getin: five idle waits with busy control outputs, then handshake.
    do_reset();
    launch(1);
    do_instr("getin", 1, 16'h0004, 3'd5, 2'd2, 1'b1, 1'b1, 5, 4'b0000);
    do_instr("after_getin", 1, 16'h0000, 3'd2, 2'd0, 1'b0, 1'b1, 0, 4'b1001);

    // Halt: sticky, ignores start, not counted; reset clears it.
    do_reset();
    launch(0);
    do_instr("pre_halt", 0, 16'h0000, 3'd2, 2'd0, 1'b0, 1'b1, 0, 4'b1001);
    do_instr("halt", 0, 16'h0003, 3'd1, 2'd1, 1'b1, 1'b1, 0, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      start_v[0] = 1'(i & 1);
      cyc("halt_hold", 0, e_halt());
    end
    do_reset();
    cyc("post_halt_idle", 0, e_st(3'd0));

    // Reset in the second FETCH cycle of a latency-4 fetch.
    launch(2);
    do_instr("pre_abort", 2, 16'h0000, 3'd2, 2'd0, 1'b0, 1'b1, 0, 4'b1001);
    start_v[2] = 1'b0;
    cyc("abort_fetch0", 2, e_fetch(1'b0));
    do_reset();
    for (int i = 0; i < 6; i++) cyc("post_abort", 2, e_st(3'd0));

    // Retired counter wrap past 2^CNT_W.
    do_reset();
    launch(0);
    for (int i = 0; i < 40; i++) begin
      rand_instr("wrap", 0, 0, hlt);
    end

    // Random sessions until halt or instruction budget runs out.
    for (int s = 0; s < 12; s++) begin
      int g;
      g = int'($urandom_range(NDUT - 1, 0));
      do_reset();
      launch(g);
      for (int i = 0; i < 25; i++) begin
        rand_instr("rand", g, 1, hlt);
        if (hlt) begin
          for (int k = 0; k < 3; k++) begin
            start_v[g] = rbit();
            cyc("rand_halt", g, e_halt());
          end
          break;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Multi-cycle sequencer for the stack processor datapath. It steps each instruction through fetch, decode and execute, and gates the combinational control unit's decoded outputs into one-cycle write strobes.
- Owns the input-port handshake for getin, the halt condition and a retired-instruction counter.
- Sits between the control unit and the datapath write enables (IR, data stack, return stack, memory, PC).

Parameters:
- MEM_LATENCY, 1, cycles an instruction fetch occupies before IR is written (1..15).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE and begin fetching
- inst  in  16  current IR contents (opcode class decode: inst[15:12]; zero-class function: inst[3:0])
- ctl_stackOP  in  3  control unit stackOP
- ctl_rStackOP  in  2  control unit rStackOP
- ctl_MemWrite  in  1  control unit MemWrite
- ctl_PCWrite  in  1  control unit PCWrite
- in_valid  in  1  input port has data
- in_ready  out  1  sequencer accepting input data
- mem_rd  out  1  instruction memory read active
- ir_we  out  1  IR write strobe
- stack_en  out  1  data-stack operation strobe
- rstack_en  out  1  return-stack operation strobe
- mem_we  out  1  data memory write strobe
- pc_we  out  1  PC write strobe
- halted  out  1  processor halted
- state  out  3  current FSM state code
- retired  out  CNT_W  instructions completed

Behaviour:
- State codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WAIT_IN=4, HALT=5. Codes 6 and 7 are illegal and return to IDLE on the next clock.
- Reset, asynchronous: state=IDLE, fetch counter=0, retired=0. All strobes, in_ready and halted are 0.
- IDLE: mem_rd=0. When start=1, go to FETCH on the next clock.
- FETCH:
  - mem_rd=1 for exactly MEM_LATENCY cycles, timed by an internal down-counter.
  - ir_we=1 in the last of those cycles only, then go to DECODE.
- DECODE: one cycle, no strobes. It lets the control outputs settle on the new IR.
- Classification, combinational from inst:
  - halt = inst==16'h0003.
  - getin = inst==16'h0004.
  - All other encodings are normal instructions.
- DECODE exit: halt -> HALT; getin -> WAIT_IN; otherwise -> EXEC.
- EXEC: one cycle.
  - stack_en = (ctl_stackOP!=0); rstack_en = (ctl_rStackOP!=0); mem_we = ctl_MemWrite; pc_we = ctl_PCWrite.
  - retired increments by 1. Next state is FETCH.
- WAIT_IN:
  - in_ready=1 and no other strobes while in_valid=0.
  - On the cycle in_valid=1: stack_en=1, pc_we=1, retired+1, next state FETCH.
- HALT: halted=1 and all strobes 0. Only reset leaves HALT; start is ignored. Halt is not counted in retired.
- Strobes are single-cycle pulses. No strobe is ever asserted in IDLE, DECODE or HALT.
- retired wraps modulo 2^CNT_W.
- start held high continuously has no effect outside IDLE.
- Reset asserted mid-FETCH or mid-WAIT_IN aborts immediately with no partial strobes.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- When defined, the block adds input step (1 bit) and state PAUSE=6.
  - Every instruction completion goes to PAUSE instead of FETCH: EXEC exit, and the WAIT_IN handshake cycle.
  - PAUSE issues no strobes. A one-cycle step=1 moves to FETCH.
- When undefined, there is no step port, and code 6 is illegal as above.

Decomposition:
- Shared package stack_pkg holds:
  - state encoding constants
  - opcode constants: OP_HALT=16'h0003, OP_GETIN=16'h0004
  - stackOP/rStackOP "none"=0 constants, shared with the control unit
- One natural sub-module, seq_fetch_timer: loadable MEM_LATENCY down-counter with a done flag, used by FETCH.

Test Plan:
- Reset, then start=1 for one cycle, MEM_LATENCY=1, inst=16'h0000 (add, ctl_stackOP=2, ctl_PCWrite=1) -> state sequence 1,2,3,1. ir_we pulses once; the EXEC cycle shows stack_en=1, pc_we=1, mem_we=0, rstack_en=0; retired=1.
- MEM_LATENCY=3, inst=16'h5000 (pop, ctl_MemWrite=1, ctl_stackOP=3) -> mem_rd high 3 cycles, ir_we only on the third, then mem_we=1 and stack_en=1 in EXEC.
- inst=16'h0004 with in_valid low for 5 cycles, then high -> in_ready=1 for 6 cycles, then stack_en=1 and pc_we=1 on the handshake cycle, then FETCH; retired+1.
- inst=16'h0003 -> HALT with halted=1; 20 cycles with start toggling produce no strobes and retired is unchanged; reset low clears to IDLE.
- inst=16'h4000 (jal, ctl_rStackOP=1, ctl_stackOP=0) -> rstack_en=1, stack_en=0, pc_we=1 in EXEC.
- Reset pulsed low mid-FETCH (MEM_LATENCY=4, cycle 2) -> outputs zero immediately, state=0, retired=0, and no ir_we follows.
